// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-PC generator with stall-deferred redirects and a
// circular return-address stack (RAS). All outputs come straight from flops.
module pc_sequencer #(
   parameter int unsigned     PC_W      = 16,
   parameter int unsigned     COND_W    = 8,
   parameter int unsigned     UNCOND_W  = 11,
   parameter int unsigned     LINK_W    = 6,
   parameter int unsigned     RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [PC_W-1:0]     br_pc,
   input  logic [1:0]          branch_type,
   input  logic                br_taken,
   input  logic                reg_branch,
   input  logic                ret,
   input  logic [COND_W-1:0]   cond_offset,
   input  logic [UNCOND_W-1:0] uncond_offset,
   input  logic [LINK_W-1:0]   link_offset,
   input  logic [PC_W-1:0]     register_data_2,
   output logic [PC_W-1:0]     pc_out,
   output logic                pc_valid,
   output logic [PC_W-1:0]     link_pc,
   output logic                flush,
   output logic                ras_empty,
   output logic                ras_full,
   output logic                ras_overflow,
   output logic                ras_underflow
);
   localparam int unsigned AW      = $clog2(RAS_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(RAS_DEPTH);

   // Everything needed to resolve a redirect later, captured as one unit
   typedef struct packed {
      logic [PC_W-1:0]     br_pc;
      logic [1:0]          btype;
      logic                taken;
      logic                reg_br;
      logic                ret;
      logic [COND_W-1:0]   cond_off;
      logic [UNCOND_W-1:0] uncond_off;
      logic [LINK_W-1:0]   link_off;
      logic [PC_W-1:0]     reg_data;
   } redir_t;

   redir_t          in_req, req, pend_q, pend_d;
   logic            pend_vld_q, pend_vld_d;
   logic [PC_W-1:0] pc_q, pc_d, link_q, link_d, seq;
   logic [PC_W-1:0] c_ext, u_ext, l_ext;
   logic            vld_q, flush_q, flush_d, run, apply;
   logic [PC_W-1:0] ras_q [RAS_DEPTH];
   logic [AW-1:0]   ptr_q, ptr_d, top_idx;
   logic [AW:0]     cnt_q, cnt_d;
   logic            empty_q, full_q, ovf_q, ovf_d, unf_q, unf_d;
   logic            push, pop;

   // Bundle the live redirect inputs
   always_comb begin
      in_req            = '0;
      in_req.br_pc      = br_pc;
      in_req.btype      = branch_type;
      in_req.taken      = br_taken;
      in_req.reg_br     = reg_branch;
      in_req.ret        = ret;
      in_req.cond_off   = cond_offset;
      in_req.uncond_off = uncond_offset;
      in_req.link_off   = link_offset;
      in_req.reg_data   = register_data_2;
   end

   // Next PC, pending capture, and RAS push/pop decisions
   always_comb begin
      // The first edge after reset only raises pc_valid, so it behaves as a stall
      run        = vld_q & ~stall;
      apply      = run & (redirect_valid | pend_vld_q);
      // A fresh redirect always wins over a deferred one
      req        = redirect_valid ? in_req : pend_q;
      seq        = req.br_pc + PC_W'(1);
      c_ext      = {{(PC_W-COND_W){req.cond_off[COND_W-1]}}, req.cond_off};
      u_ext      = {{(PC_W-UNCOND_W){req.uncond_off[UNCOND_W-1]}}, req.uncond_off};
      l_ext      = {{(PC_W-LINK_W){req.link_off[LINK_W-1]}}, req.link_off};
      top_idx    = ptr_q - AW'(1);
      pc_d       = pc_q;
      link_d     = link_q;
      flush_d    = 1'b0;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      push       = 1'b0;
      pop        = 1'b0;
      unf_d      = unf_q;
      if (!run) begin
         if (redirect_valid) begin
            pend_d     = in_req;
            pend_vld_d = 1'b1;
         end
      end else begin
         pend_vld_d = 1'b0;
         if (!apply) begin
            pc_d = pc_q + PC_W'(1);
         end else begin
            flush_d = 1'b1;
            if (req.ret) begin
               if (cnt_q != '0) begin
                  pc_d = ras_q[top_idx];
                  pop  = 1'b1;
               end else begin
                  pc_d  = seq;
                  unf_d = 1'b1;
               end
            end else if (req.reg_br) begin
               pc_d = req.reg_data;
            end else if (req.btype == 2'b01 && req.taken) begin
               pc_d = req.br_pc + c_ext;
            end else if (req.btype == 2'b10) begin
               pc_d = req.br_pc + u_ext;
            end else if (req.btype == 2'b11) begin
               pc_d   = req.br_pc + l_ext;
               push   = 1'b1;
               link_d = seq;
            end else begin
               pc_d = seq;
            end
         end
      end
   end

   // RAS pointer/count: a push when full overwrites the oldest slot
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (push) begin
         ptr_d = ptr_q + AW'(1);
         if (cnt_q == DEPTH_C) ovf_d = 1'b1;
         else                  cnt_d = cnt_q + (AW+1)'(1);
      end else if (pop) begin
         ptr_d = top_idx;
         cnt_d = cnt_q - (AW+1)'(1);
      end
   end

   // RAS storage needs no reset: the count gates every read
   always_ff @(posedge clk) begin
      if (push) ras_q[ptr_q] <= seq;
   end

   // Architectural state with asynchronous reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         vld_q      <= 1'b0;
         link_q     <= '0;
         flush_q    <= 1'b0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         vld_q      <= 1'b1;
         link_q     <= link_d;
         flush_q    <= flush_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         empty_q    <= (cnt_d == '0);
         full_q     <= (cnt_d == DEPTH_C);
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   assign pc_out        = pc_q;
   assign pc_valid      = vld_q;
   assign link_pc       = link_q;
   assign flush         = flush_q;
   assign ras_empty     = empty_q;
   assign ras_full      = full_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have one clock and one asynchronous, active-low reset (clk, reset).
REQ-002 Parameter PC_W, default 16: PC and register-target width.
REQ-003 Parameter COND_W, default 8: conditional-branch offset width, signed.
REQ-004 Parameter UNCOND_W, default 11: unconditional-branch offset width, signed.
REQ-005 Parameter LINK_W, default 6: branch-and-link offset width, signed.
REQ-006 Parameter RAS_DEPTH, default 4, power of two, minimum 2: return-address-stack entries.
REQ-007 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-008 Ports, in order (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold the PC; redirects are deferred
- redirect_valid  in  1  a resolved control-flow event is presented
- br_pc  in  PC_W  PC of the resolving instruction
- branch_type  in  2  00 sequential, 01 conditional, 10 unconditional, 11 branch-and-link
- br_taken  in  1  condition outcome for type 01
- reg_branch  in  1  register-indirect target
- ret  in  1  return; pop the RAS
- cond_offset  in  COND_W  signed offset for type 01
- uncond_offset  in  UNCOND_W  signed offset for type 10
- link_offset  in  LINK_W  signed offset for type 11
- register_data_2  in  PC_W  register-indirect target
- pc_out  out  PC_W  current fetch PC
- pc_valid  out  1  pc_out is valid for fetch
- link_pc  out  PC_W  last return address pushed
- flush  out  1  one-cycle pulse when the PC is redirected
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_overflow  out  1  sticky flag: a push occurred while the RAS was full
- ras_underflow  out  1  sticky flag: a pop occurred while the RAS was empty

Function
REQ-009 All PC arithmetic SHALL be modulo 2^PC_W, and each offset SHALL be sign-extended to PC_W before the add.
REQ-010 Target selection, highest priority first:
- ret: RAS top, and pop
- reg_branch: register_data_2
- type 01 with br_taken=1: br_pc + cond_offset
- type 10: br_pc + uncond_offset
- type 11: br_pc + link_offset, push br_pc+1, and link_pc <= br_pc+1
- otherwise: br_pc + 1
REQ-011 ret with an empty RAS SHALL use target br_pc+1, SHALL set ras_underflow, and SHALL leave the RAS unchanged.
REQ-012 A push with a full RAS SHALL overwrite the oldest entry (circular), SHALL keep the count at RAS_DEPTH, and SHALL set ras_overflow.
REQ-013 With stall=0 and no redirect, pc_out SHALL advance by 1 on each clock; pc_out=2^PC_W-1 SHALL wrap to 0.
REQ-014 With stall=0 and redirect_valid=1, pc_out SHALL equal the target on the next edge and flush SHALL be 1 for exactly that cycle.
REQ-015 A redirect resolving to br_pc+1 SHALL still load the target and pulse flush.
REQ-016 With stall=1, pc_out, the RAS and link_pc SHALL hold, and flush SHALL be 0.
REQ-017 A redirect with stall=1 SHALL be captured in a one-entry pending register, together with all of its inputs.
REQ-018 A later redirect during the same stall SHALL overwrite the pending entry.
REQ-019 The RAS and link_pc side effects of a redirect SHALL occur only when it is applied, never on capture.
REQ-020 On the first cycle with stall=0, a pending redirect SHALL be applied exactly as in REQ-014, and the pending register SHALL clear.
REQ-021 A fresh redirect_valid in that same cycle SHALL take priority; the pending entry SHALL be discarded and SHALL have no RAS side effect.
REQ-022 Redirect latency SHALL be 1 clock from the applying edge; the block SHALL contain no combinational path from any input to pc_out.
REQ-023 ras_empty and ras_full SHALL be registered, and SHALL reflect the entry count after each edge.

Reset
REQ-024 While reset=0 the block SHALL force pc_out=RESET_PC, pc_valid=0, link_pc=0, flush=0, RAS count 0 (ras_empty=1, ras_full=0), ras_overflow=0, ras_underflow=0, and pending cleared, asynchronously.
REQ-025 pc_valid SHALL rise on the first rising edge after reset deasserts; on that edge pc_out SHALL remain RESET_PC and SHALL advance from the next edge.
REQ-026 Reset asserted mid-stall or with a redirect pending SHALL discard all state; no pending redirect SHALL survive reset.

Verification
REQ-027 Reset release, no stall -> pc_valid=1 with pc_out=0; then 1, 2, 3 on successive edges; flush=0 throughout.
REQ-028 Wrap case, PC_W=16, free-run from 16'hFFFE -> pc_out reads FFFE, FFFF, 0000.
REQ-029 Link then return:
- redirect, type 11, br_pc=0x0010, link_offset=6'h3C (-4) -> pc_out=0x000C, link_pc=0x0011, flush pulse, ras_empty=0
- then ret -> pc_out=0x0011, ras_empty=1
REQ-030 Stall deferral:
- stall=1, conditional redirect br_pc=0x0020, cond_offset=8'h10, br_taken=1 -> pc_out held, flush=0
- a second redirect during the same stall, type 10, uncond_offset=+2, br_pc=0x0030 -> overwrites the pending entry
- stall released -> pc_out=0x0032 next edge, one flush pulse
REQ-031 RAS_DEPTH=4:
- five link redirects with br_pc=0x100..0x104 -> ras_full=1, ras_overflow=1
- four rets -> targets 0x105, 0x104, 0x103, 0x102
- fifth ret -> target br_pc+1, ras_underflow=1
REQ-032 reset=0 asserted asynchronously mid-stall with a redirect pending -> all outputs at reset values immediately, with no clock edge required.
